membrane_update_unit: RTL and testbench

- Consumes the per-synapse-class IPSC currents (Q INTEGER_WIDTH.DATA_WIDTH_FRAC signed) produced by the IPSC stage for one neuron per time step.
- Sums them with saturation, integrates the sum into the neuron membrane potential, then applies refractory hold, threshold test and reset.
- Emits the updated Vmem, refractory count and spike flag, tagged with the neuron ID, to the neuron state writeback.
- Processes one neuron at a time; uses valid/ready handshakes on all three interfaces.

---
 rtl/membrane_update_unit.sv | 218 +++++++++++++++++++++
 tb/tb_membrane_update_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/membrane_update_unit.sv
// ============================================================================
// membrane_update_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Handles one neuron per time step. It sums the neuron's per-synapse-class
//   IPSC currents with saturation and adds the sum to the membrane potential,
//   again with saturation. It then applies refractory hold, the threshold test
//   and reset. The result goes to the neuron-state writeback, tagged with the
//   neuron ID.
//   All data is signed fixed point: INTEGER_WIDTH integer bits and
//   DATA_WIDTH_FRAC fractional bits.
//
// Ports:
//   i_clock, i_reset       rising-edge clock, asynchronous active-high reset
//   i_start, o_startReady  begin a neuron (accepted only while idle)
//   i_noInput              neuron has no IPSC contributions this step
//   i_neuronIdIn           ID tag, latched at start
//   i_vmemIn/i_vthIn/i_vresetIn  membrane, threshold and reset potentials
//   i_refIn, i_refPeriod   remaining refractory steps / reload value on spike
//   i_ipscIn, i_ipscValid, i_ipscLast, o_ipscReady  IPSC contribution stream
//   o_vmemOut, o_refOut, o_spikeOut, o_neuronIdOut  updated neuron state
//   o_outValid, i_outReady result handshake
// ============================================================================
module membrane_update_unit #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int REF_WIDTH       = 8,
    parameter int NID_WIDTH       = 16
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    output logic                         o_startReady,
    input  logic                         i_noInput,
    input  logic [NID_WIDTH-1:0]         i_neuronIdIn,
    input  logic signed [DATA_WIDTH-1:0] i_vmemIn,
    input  logic signed [DATA_WIDTH-1:0] i_vthIn,
    input  logic signed [DATA_WIDTH-1:0] i_vresetIn,
    input  logic [REF_WIDTH-1:0]         i_refIn,
    input  logic [REF_WIDTH-1:0]         i_refPeriod,
    input  logic signed [DATA_WIDTH-1:0] i_ipscIn,
    input  logic                         i_ipscValid,
    input  logic                         i_ipscLast,
    output logic                         o_ipscReady,
    output logic signed [DATA_WIDTH-1:0] o_vmemOut,
    output logic [REF_WIDTH-1:0]         o_refOut,
    output logic                         o_spikeOut,
    output logic [NID_WIDTH-1:0]         o_neuronIdOut,
    output logic                         o_outValid,
    input  logic                         i_outReady
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [REF_WIDTH-1:0]         REF_ONE = {{(REF_WIDTH-1){1'b0}}, 1'b1};

    state_t                         r_state;
    state_t                         w_nextState;

    logic signed [DATA_WIDTH-1:0]   r_vmem;
    logic signed [DATA_WIDTH-1:0]   r_vth;
    logic signed [DATA_WIDTH-1:0]   r_vreset;
    logic [REF_WIDTH-1:0]           r_ref;
    logic [REF_WIDTH-1:0]           r_refPeriod;
    logic [NID_WIDTH-1:0]           r_neuronId;
    logic signed [DATA_WIDTH-1:0]   r_acc;

    logic signed [DATA_WIDTH-1:0]   r_vmemOut;
    logic [REF_WIDTH-1:0]           r_refOut;
    logic                           r_spikeOut;
    logic [NID_WIDTH-1:0]           r_neuronIdOut;
    logic                           r_outValid;

    logic signed [DATA_WIDTH-1:0]   w_accSum;
    logic signed [DATA_WIDTH-1:0]   w_vnew;
    logic                           w_fire;

    // Saturating signed add. Overflow is only possible when both operands
    // have the same sign and the wrapped result has the other sign. The clamp
    // direction then follows the operands' shared sign.
    function automatic logic signed [DATA_WIDTH-1:0] satAdd(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH-1:0] s;
        s = a + b;
        if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]))
            return a[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
        else
            return s;
    endfunction

    // Next accumulator value, the candidate membrane potential, and the
    // signed threshold test that decides whether the neuron fires.
    always_comb begin
        w_accSum = satAdd(r_acc, i_ipscIn);
        w_vnew   = satAdd(r_vmem, r_acc);
        w_fire   = (w_vnew >= r_vth);
    end

    // State register. An asynchronous reset returns to IDLE from any state
    // and drops the neuron that was in flight.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // Next-state logic and the two ready strobes. The ready strobes come
    // straight from the current state, so they are valid in the same cycle.
    always_comb begin
        w_nextState  = r_state;
        o_startReady = 1'b0;
        o_ipscReady  = 1'b0;
        case (r_state)
            IDLE: begin
                o_startReady = 1'b1;
                if (i_start)
                    w_nextState = i_noInput ? UPDATE : ACCUM;
            end
            ACCUM: begin
                o_ipscReady = 1'b1;
                if (i_ipscValid && i_ipscLast)
                    w_nextState = UPDATE;
            end
            UPDATE: begin
                w_nextState = HOLD;
            end
            HOLD: begin
                if (i_outReady)
                    w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: latch neuron parameters at start and accumulate IPSCs.
    // The single UPDATE cycle computes the registered result. That result
    // stays frozen through HOLD until downstream accepts it.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_vmem        <= '0;
            r_vth         <= '0;
            r_vreset      <= '0;
            r_ref         <= '0;
            r_refPeriod   <= '0;
            r_neuronId    <= '0;
            r_acc         <= '0;
            r_vmemOut     <= '0;
            r_refOut      <= '0;
            r_spikeOut    <= 1'b0;
            r_neuronIdOut <= '0;
            r_outValid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_vmem      <= i_vmemIn;
                        r_vth       <= i_vthIn;
                        r_vreset    <= i_vresetIn;
                        r_ref       <= i_refIn;
                        r_refPeriod <= i_refPeriod;
                        r_neuronId  <= i_neuronIdIn;
                        r_acc       <= '0;
                    end
                end
                ACCUM: begin
                    if (i_ipscValid)
                        r_acc <= w_accSum;
                end
                UPDATE: begin
                    // A refractory neuron holds at reset and ignores its
                    // input current for this step.
                    if (r_ref != '0) begin
                        r_vmemOut  <= r_vreset;
                        r_refOut   <= r_ref - REF_ONE;
                        r_spikeOut <= 1'b0;
                    end else if (w_fire) begin
                        r_vmemOut  <= r_vreset;
                        r_refOut   <= r_refPeriod;
                        r_spikeOut <= 1'b1;
                    end else begin
                        r_vmemOut  <= w_vnew;
                        r_refOut   <= '0;
                        r_spikeOut <= 1'b0;
                    end
                    r_neuronIdOut <= r_neuronId;
                    r_outValid    <= 1'b1;
                end
                HOLD: begin
                    if (i_outReady)
                        r_outValid <= 1'b0;
                end
                default: begin
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign o_vmemOut     = r_vmemOut;
    assign o_refOut      = r_refOut;
    assign o_spikeOut    = r_spikeOut;
    assign o_neuronIdOut = r_neuronIdOut;
    assign o_outValid    = r_outValid;

endmodule

// File: tb/tb_membrane_update_unit.sv
// ============================================================================
// tb_membrane_update_unit
// ----------------------------------------------------------------------------
// Directed and randomized neurons for membrane_update_unit. Expected results
// come from a reference model that works on whole IPSC lists. It uses
// wide-integer saturation, computed as plain arithmetic on the integrate /
// refractory / fire rules.
// ============================================================================
module tb_membrane_update_unit;

    localparam int DW = 64;
    localparam int RW = 8;
    localparam int NW = 16;

    localparam logic signed [DW-1:0] VMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [DW-1:0] VMIN = 64'sh8000_0000_0000_0000;
    localparam logic signed [DW:0]   WMAX = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [DW:0]   WMIN = -65'sh0_8000_0000_0000_0000;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 startReady;
    logic                 noInput;
    logic [NW-1:0]        neuronIdIn;
    logic signed [DW-1:0] vmemIn;
    logic signed [DW-1:0] vthIn;
    logic signed [DW-1:0] vresetIn;
    logic [RW-1:0]        refIn;
    logic [RW-1:0]        refPeriod;
    logic signed [DW-1:0] ipscIn;
    logic                 ipscValid;
    logic                 ipscLast;
    logic                 ipscReady;
    logic signed [DW-1:0] vmemOut;
    logic [RW-1:0]        refOut;
    logic                 spikeOut;
    logic [NW-1:0]        neuronIdOut;
    logic                 outValid;
    logic                 outReady;

    int errors = 0;
    int checks = 0;

    logic signed [DW-1:0] ipscQ[$];

    membrane_update_unit #(
        .INTEGER_WIDTH(32), .DATA_WIDTH_FRAC(32), .DATA_WIDTH(DW),
        .REF_WIDTH(RW), .NID_WIDTH(NW)
    ) dut (
        .i_clock(clock), .i_reset(reset), .i_start(start), .o_startReady(startReady),
        .i_noInput(noInput), .i_neuronIdIn(neuronIdIn), .i_vmemIn(vmemIn),
        .i_vthIn(vthIn), .i_vresetIn(vresetIn), .i_refIn(refIn), .i_refPeriod(refPeriod),
        .i_ipscIn(ipscIn), .i_ipscValid(ipscValid), .i_ipscLast(ipscLast),
        .o_ipscReady(ipscReady), .o_vmemOut(vmemOut), .o_refOut(refOut),
        .o_spikeOut(spikeOut), .o_neuronIdOut(neuronIdOut), .o_outValid(outValid),
        .i_outReady(outReady)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Q32.32 value from an integer part and a fractional bit pattern.
    function automatic logic signed [DW-1:0] fx(input int ip, input logic [31:0] fr);
        return {ip, fr};
    endfunction

    // Saturating add done in a wider integer and clamped to the 64-bit range.
    function automatic logic signed [DW-1:0] satModel(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        logic signed [DW:0] w;
        w = 65'(a) + 65'(b);
        if (w > WMAX) return VMAX;
        if (w < WMIN) return VMIN;
        return w[DW-1:0];
    endfunction

    // Reference model for one neuron step over the whole ipscQ list.
    function automatic void refModel(input logic signed [DW-1:0] vm, vth, vr,
                                     input int rIn, rPer,
                                     output logic signed [DW-1:0] eV,
                                     output int eRef, output bit eSpike);
        logic signed [DW-1:0] acc;
        logic signed [DW-1:0] vnew;
        acc = '0;
        foreach (ipscQ[i]) acc = satModel(acc, ipscQ[i]);
        if (rIn != 0) begin
            eV = vr; eRef = rIn - 1; eSpike = 1'b0;
        end else begin
            vnew = satModel(vm, acc);
            if (vnew >= vth) begin
                eV = vr; eRef = rPer; eSpike = 1'b1;
            end else begin
                eV = vnew; eRef = 0; eSpike = 1'b0;
            end
        end
    endfunction

    // One comparison: count it, and report a failure with the observed and
    // expected values.
    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Run one neuron from start to accepted result. ipscQ holds its
    // contributions (empty when noInp is set). gaps inserts random bubbles
    // in the IPSC stream. holdCycles keeps outReady low for that many cycles,
    // and hsStart pulses start while the result is being held.
    task automatic applyStimulus(input string tag,
                                 input logic signed [DW-1:0] vm, vth, vr,
                                 input int rIn, rPer, input int nid,
                                 input bit noInp, input bit gaps,
                                 input int holdCycles, input bit hsStart);
        logic signed [DW-1:0] eV;
        int eRef;
        bit eSpike;
        refModel(vm, vth, vr, rIn, rPer, eV, eRef, eSpike);
        @(negedge clock);
        checkOutput({tag, ".startReady"}, 64'(startReady), 64'(1));
        start = 1'b1; noInput = noInp; vmemIn = vm; vthIn = vth; vresetIn = vr;
        refIn = RW'(rIn); refPeriod = RW'(rPer); neuronIdIn = NW'(nid);
        @(negedge clock);
        start = 1'b0;
        vmemIn = {$urandom, $urandom}; vthIn = {$urandom, $urandom};
        vresetIn = {$urandom, $urandom}; refIn = RW'($urandom);
        refPeriod = RW'($urandom); neuronIdIn = NW'($urandom);
        if (!noInp) begin
            for (int i = 0; i < ipscQ.size(); i++) begin
                if (i == 0) checkOutput({tag, ".ipscReady"}, 64'(ipscReady), 64'(1));
                if (gaps && $urandom_range(0, 1) == 1) begin
                    ipscValid = 1'b0; ipscLast = 1'($urandom_range(0, 1));
                    ipscIn = {$urandom, $urandom};
                    @(negedge clock);
                end
                ipscValid = 1'b1; ipscIn = ipscQ[i]; ipscLast = (i == ipscQ.size() - 1);
                @(negedge clock);
            end
            ipscValid = 1'b0; ipscLast = 1'b0;
        end
        checkOutput({tag, ".validEarly"}, 64'(outValid), 64'(0));
        @(negedge clock);
        checkOutput({tag, ".outValid"}, 64'(outValid), 64'(1));
        checkOutput({tag, ".vmem"}, vmemOut, eV);
        checkOutput({tag, ".ref"}, 64'(refOut), 64'(eRef));
        checkOutput({tag, ".spike"}, 64'(spikeOut), 64'(eSpike));
        checkOutput({tag, ".nid"}, 64'(neuronIdOut), 64'(nid));
        for (int h = 0; h < holdCycles; h++) begin
            outReady = 1'b0;
            if (hsStart && h == 0) begin start = 1'b1; noInput = 1'b1; end
            @(negedge clock);
            start = 1'b0;
            checkOutput({tag, ".holdValid"}, 64'(outValid), 64'(1));
            checkOutput({tag, ".holdVmem"}, vmemOut, eV);
            checkOutput({tag, ".holdStartReady"}, 64'(startReady), 64'(0));
        end
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
        checkOutput({tag, ".released"}, 64'(outValid), 64'(0));
        checkOutput({tag, ".idle"}, 64'(startReady), 64'(1));
    endtask

    initial begin
        int ip;
        bit ni;
        int rr;
        reset = 1'b1; start = 1'b0; noInput = 1'b0; neuronIdIn = '0;
        vmemIn = '0; vthIn = '0; vresetIn = '0; refIn = '0; refPeriod = '0;
        ipscIn = '0; ipscValid = 1'b0; ipscLast = 1'b0; outReady = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset.outValid", 64'(outValid), 64'(0));
        checkOutput("reset.vmem", vmemOut, 64'(0));
        checkOutput("reset.ref", 64'(refOut), 64'(0));
        checkOutput("reset.spike", 64'(spikeOut), 64'(0));
        checkOutput("reset.ipscReady", 64'(ipscReady), 64'(0));
        checkOutput("reset.startReady", 64'(startReady), 64'(1));
        reset = 1'b0;

        // Basic integrate: -65 + 3 + 2.5 - 1 = -60.5, no spike.
        ipscQ = '{fx(3, 0), fx(2, 32'h8000_0000), fx(-1, 0)};
        applyStimulus("basic", fx(-65, 0), fx(-50, 0), fx(-70, 0), 0, 5, 16'h0011, 0, 0, 0, 0);

        // Fire exactly at threshold: -52 + 2 = -50.
        ipscQ = '{fx(2, 0)};
        applyStimulus("fire", fx(-52, 0), fx(-50, 0), fx(-70, 0), 0, 5, 16'h0022, 0, 0, 0, 0);

        // Refractory hold discards a large input.
        ipscQ = '{fx(100, 0)};
        applyStimulus("refr", fx(-65, 0), fx(-50, 0), fx(-70, 0), 3, 5, 16'h0033, 0, 0, 0, 0);

        // NoInput path with the last refractory step.
        ipscQ.delete();
        applyStimulus("noinp", fx(-65, 0), fx(-50, 0), fx(-70, 0), 1, 5, 16'h0044, 1, 0, 0, 0);

        // Positive saturation to the maximum, which reaches a maximum threshold.
        ipscQ = '{64'sh7FFF_FFFF_0000_0000, 64'sh7FFF_FFFF_0000_0000};
        applyStimulus("satPos", 64'sd0, VMAX, VMAX, 0, 7, 16'h0055, 0, 0, 0, 0);

        // Negative saturation to the minimum, no spike.
        ipscQ = '{64'sh8000_0001_0000_0000, 64'sh8000_0001_0000_0000};
        applyStimulus("satNeg", 64'sd0, VMAX, fx(-70, 0), 0, 7, 16'h0066, 0, 0, 0, 0);

        // Bubbles on IPSC, four held cycles and an ignored start in HOLD.
        ipscQ = '{fx(1, 0), fx(2, 0), fx(-3, 32'h4000_0000), fx(4, 0)};
        applyStimulus("bp", fx(-60, 0), fx(-50, 0), fx(-70, 0), 0, 5, 16'h0077, 0, 1, 4, 1);

        // Reset in the middle of ACCUM, after 2 of 4 contributions.
        @(negedge clock);
        start = 1'b1; noInput = 1'b0; vmemIn = fx(-40, 0); vthIn = fx(-50, 0);
        vresetIn = fx(-70, 0); refIn = '0; refPeriod = 8'd9; neuronIdIn = 16'h0BAD;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ipscValid = 1'b1; ipscIn = fx(30, 0); ipscLast = 1'b0;
            @(negedge clock);
        end
        ipscValid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("midReset.outValid", 64'(outValid), 64'(0));
        checkOutput("midReset.ipscReady", 64'(ipscReady), 64'(0));
        checkOutput("midReset.startReady", 64'(startReady), 64'(1));
        @(negedge clock);
        reset = 1'b0;
        ipscQ = '{fx(1, 0), fx(1, 0)};
        applyStimulus("afterReset", fx(-65, 0), fx(-50, 0), fx(-70, 0), 0, 5, 16'h0088, 0, 0, 0, 0);

        // Randomized neurons checked against the reference model.
        for (int n = 0; n < 10; n++) begin
            ipscQ.delete();
            ni = ($urandom_range(0, 4) == 0);
            if (!ni) begin
                for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
                    ip = int'($urandom_range(0, 16)) - 8;
                    ipscQ.push_back(fx(ip, $urandom));
                end
            end
            rr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            ip = -80 + int'($urandom_range(0, 35));
            applyStimulus($sformatf("rand%0d", n), fx(ip, $urandom), fx(-50, 0), fx(-70, 0),
                          rr, int'($urandom_range(1, 10)), int'($urandom_range(0, 65535)),
                          ni, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
